// File: rtl/door_code_sender_pkg.sv
// Shared door-lock link constants: code width, frame geometry and slot numbering,
// plus the helper that picks the code bit carried by a given frame slot.
package door_code_sender_pkg;

    localparam int CODE_W     = 4;
    localparam int FRAME_LEN  = 8;
    localparam int FIRST_SLOT = 1;
    localparam int SLOT_W     = 3;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [CODE_W-1:0] code_t;

    localparam code_t PASSWORD = 4'b1010;

    localparam slot_t SLOT_IDLE     = 3'd0;
    localparam slot_t SLOT_BIT0     = SLOT_W'(FIRST_SLOT);
    localparam slot_t SLOT_BIT_LAST = SLOT_W'(FIRST_SLOT + CODE_W - 1);
    localparam slot_t SLOT_CHECK    = 3'd6;
    localparam slot_t SLOT_RESULT   = 3'd7;
    localparam slot_t SLOT_LAST     = SLOT_W'(FRAME_LEN - 1);
    localparam slot_t RESP_SLOT     = 3'd0;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // Bit of c carried in slot s (MSB first from SLOT_BIT0), 0 outside the data slots.
    function automatic logic frame_bit(input code_t c, input slot_t s);
        code_t shifted;
        shifted = c << (s - SLOT_BIT0);
        if ((s >= SLOT_BIT0) && (s <= SLOT_BIT_LAST)) begin
            return shifted[CODE_W-1];
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/door_code_sender_if.sv
// Requester/lock-facing signal bundle of the door code sender.
interface door_code_sender_if;

    logic                        code_valid;
    door_code_sender_pkg::code_t code;
    logic                        code_ready;
    logic                        serial_out;
    logic                        unlock_in;
    logic                        error_in;
    logic                        busy;
    logic                        result_valid;
    logic                        granted;
    logic                        denied;
    logic                        sync_err;

    modport master (
        output code_valid, code, unlock_in, error_in,
        input  code_ready, serial_out, busy, result_valid, granted, denied, sync_err
    );

    modport slave (
        input  code_valid, code, unlock_in, error_in,
        output code_ready, serial_out, busy, result_valid, granted, denied, sync_err
    );

endinterface

// File: rtl/door_code_sender_frame_timer.sv
// Free-running lock frame slot counter with the next-slot value and response-slot strobe;
// identical timing to the lock's own counter so both stay aligned from reset release.
module door_code_sender_frame_timer
    import door_code_sender_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    output slot_t slot_r,
    output slot_t slot_next_s,
    output logic  resp_slot_s
);

    // Next slot value with wrap at the end of the frame.
    always_comb begin
        slot_next_s = SLOT_IDLE;
        if (slot_r == SLOT_LAST) begin
            slot_next_s = SLOT_IDLE;
        end else begin
            slot_next_s = slot_r + 3'd1;
        end
    end

    // Slot counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r <= SLOT_IDLE;
        end else begin
            slot_r <= slot_next_s;
        end
    end

    assign resp_slot_s = (slot_r == RESP_SLOT);

endmodule

// File: rtl/door_code_sender.sv
// Serializes one code per lock frame onto the lock input and returns the lock's verdict
// for that code one frame later; flags lock responses that break frame timing.
module door_code_sender
    import door_code_sender_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    door_code_sender_if.slave bus
);

    slot_t     slot_r;
    slot_t     slot_next_s;
    logic      resp_slot_s;
    logic      accept_s;
    tx_state_t state_r;
    tx_state_t state_next_s;
    logic      busy_s;
    code_t     code_r;
    logic      src_valid_s;
    code_t     src_code_s;
    logic      serial_next_s;
    logic      sync_bad_s;
    logic      serial_out_r;
    logic      result_valid_r;
    logic      granted_r;
    logic      denied_r;
    logic      sync_err_r;

    door_code_sender_frame_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .slot_r      (slot_r),
        .slot_next_s (slot_next_s),
        .resp_slot_s (resp_slot_s)
    );

    assign accept_s = resp_slot_s & bus.code_valid;

    // Transfer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // A code stays in flight until its verdict slot, unless a new one is taken on that edge.
    always_comb begin
        state_next_s = TX_IDLE;
        case (state_r)
            TX_IDLE: begin
                if (accept_s) begin
                    state_next_s = TX_BUSY;
                end else begin
                    state_next_s = TX_IDLE;
                end
            end
            TX_BUSY: begin
                if (resp_slot_s && !accept_s) begin
                    state_next_s = TX_IDLE;
                end else begin
                    state_next_s = TX_BUSY;
                end
            end
            default: state_next_s = TX_IDLE;
        endcase
    end

    // State decode.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            TX_BUSY: busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // In the response slot the old code is done; only a freshly accepted code may drive bits.
    always_comb begin
        src_valid_s = 1'b0;
        src_code_s  = '0;
        if (resp_slot_s) begin
            src_valid_s = accept_s;
            src_code_s  = bus.code;
        end else begin
            src_valid_s = busy_s;
            src_code_s  = code_r;
        end
        serial_next_s = src_valid_s & frame_bit(src_code_s, slot_next_s);
    end

    // Lock outputs are legal only in the response slot and must then be one-hot while busy.
    always_comb begin
        sync_bad_s = 1'b0;
        if (resp_slot_s) begin
            sync_bad_s = busy_s & (bus.unlock_in == bus.error_in);
        end else begin
            sync_bad_s = bus.unlock_in | bus.error_in;
        end
    end

    // Code holding register and serial line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_r       <= '0;
            serial_out_r <= 1'b0;
        end else begin
            serial_out_r <= serial_next_s;
            if (accept_s) begin
                code_r <= bus.code;
            end else begin
                code_r <= code_r;
            end
        end
    end

    // Verdict capture; granted/denied hold until the next verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid_r <= 1'b0;
            granted_r      <= 1'b0;
            denied_r       <= 1'b0;
        end else if (resp_slot_s && busy_s) begin
            result_valid_r <= 1'b1;
            granted_r      <= bus.unlock_in;
            denied_r       <= bus.error_in;
        end else begin
            result_valid_r <= 1'b0;
        end
    end

    // Sticky frame-sync error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err_r <= 1'b0;
        end else if (sync_bad_s) begin
            sync_err_r <= 1'b1;
        end else begin
            sync_err_r <= sync_err_r;
        end
    end

    assign bus.code_ready   = resp_slot_s;
    assign bus.serial_out   = serial_out_r;
    assign bus.busy         = busy_s;
    assign bus.result_valid = result_valid_r;
    assign bus.granted      = granted_r;
    assign bus.denied       = denied_r;
    assign bus.sync_err     = sync_err_r;

endmodule
